// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: serializes per-channel edge pulses into one valid/ready event stream
//
// Collects rising/falling edge pulses from NCH input conditioners into per-channel
// pending slots and hands them out one at a time through round-robin arbitration.
// Falling events carry the channel's press duration (saturating cycle count).
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   conditioned   per-channel conditioned level (drives the duration counters)
//   positiveedge  per-channel 1-cycle rising pulse
//   negativeedge  per-channel 1-cycle falling pulse
//   evt_valid     event presented on evt_*
//   evt_ready     consumer accepts the event when high with evt_valid
//   evt_chan      channel index of the event
//   evt_rise      1 = rising event, 0 = falling event
//   evt_dur       press duration for falling events, 0 for rising events
//   evt_ts        capture timestamp (only with EDGE_EVT_TIMESTAMP_EN)
//   overflow      sticky flag, set when any event was dropped
//   ovf_clear     synchronous clear of overflow (a simultaneous drop wins)
//
// Optional feature: define EDGE_EVT_TIMESTAMP_EN to add a 16-bit free-running
// timestamp captured per pending slot and presented on evt_ts.
module edge_event_arbiter #(
    parameter int NCH  = 4,
    parameter int IDW  = 2,
    parameter int DURW = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NCH-1:0]  conditioned,
    input  logic [NCH-1:0]  positiveedge,
    input  logic [NCH-1:0]  negativeedge,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_chan,
    output logic            evt_rise,
    output logic [DURW-1:0] evt_dur,
`ifdef EDGE_EVT_TIMESTAMP_EN
    output logic [15:0]     evt_ts,
`endif
    output logic            overflow,
    input  logic            ovf_clear
);

    localparam logic [DURW-1:0] DMAX = '1;

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t          state;
    logic [NCH-1:0]  pend_rise, pend_fall, old_fall;
    logic [DURW-1:0] cnt [NCH];
    logic [DURW-1:0] dur_cap [NCH];
    logic [IDW-1:0]  ptr, win, idx;
    logic [IDW:0]    sum;
    logic            found, load, win_rise;
    logic [NCH-1:0]  gnt_rise, gnt_fall, r_keep, f_keep, r_new, f_new, drop;

    // Round-robin scan starting at ptr; indices wrap modulo NCH without a divider.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            idx = (sum >= (IDW+1)'(NCH)) ? IDW'(sum - (IDW+1)'(NCH)) : sum[IDW-1:0];
            if (!found && (pend_rise[idx] || pend_fall[idx])) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // With both slots pending, old_fall selects which one is issued first.
    assign win_rise = pend_rise[win] & ~(pend_fall[win] & old_fall[win]);
    assign load     = (state == IDLE) | evt_ready;
    assign gnt_rise = (load & found & win_rise)  ? NCH'(1) << win : '0;
    assign gnt_fall = (load & found & ~win_rise) ? NCH'(1) << win : '0;

    // A slot granted this cycle is free to take a new pulse without a drop.
    assign r_keep = pend_rise & ~gnt_rise;
    assign f_keep = pend_fall & ~gnt_fall;
    assign r_new  = positiveedge & ~r_keep;
    assign f_new  = negativeedge & ~f_keep;
    assign drop   = (positiveedge & r_keep) | (negativeedge & f_keep);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_rise <= '0;
            pend_fall <= '0;
            old_fall  <= '0;
            overflow  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]     <= '0;
                dur_cap[i] <= '0;
            end
        end else begin
            pend_rise <= r_keep | positiveedge;
            pend_fall <= f_keep | negativeedge;
            // Order bit follows whichever slot was filled while the other was empty.
            old_fall  <= (r_keep & f_keep & old_fall) | (~r_keep & f_keep) |
                         (~r_keep & ~f_keep & f_new & ~r_new);
            overflow  <= (|drop) | (overflow & ~ovf_clear);
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= positiveedge[i] ? '0 :
                          (conditioned[i] && cnt[i] != DMAX) ? cnt[i] + 1'b1 : cnt[i];
                if (f_new[i])
                    dur_cap[i] <= (cnt[i] == DMAX) ? DMAX : cnt[i] + 1'b1;
            end
        end
    end

`ifdef EDGE_EVT_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] ts_rise [NCH];
    logic [15:0] ts_fall [NCH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts <= '0;
            for (int i = 0; i < NCH; i++) begin
                ts_rise[i] <= '0;
                ts_fall[i] <= '0;
            end
        end else begin
            ts <= ts + 16'd1;
            for (int i = 0; i < NCH; i++) begin
                if (r_new[i])
                    ts_rise[i] <= ts;
                if (f_new[i])
                    ts_fall[i] <= ts;
            end
        end
    end
`endif

    // Output register: loads a new winner whenever idle or the current event is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
            evt_chan  <= '0;
            evt_rise  <= 1'b0;
            evt_dur   <= '0;
            ptr       <= '0;
`ifdef EDGE_EVT_TIMESTAMP_EN
            evt_ts    <= '0;
`endif
        end else if (load) begin
            if (found) begin
                state     <= PRESENT;
                evt_valid <= 1'b1;
                evt_chan  <= win;
                evt_rise  <= win_rise;
                evt_dur   <= win_rise ? '0 : dur_cap[win];
                ptr       <= (win == IDW'(NCH-1)) ? '0 : win + 1'b1;
`ifdef EDGE_EVT_TIMESTAMP_EN
                evt_ts    <= win_rise ? ts_rise[win] : ts_fall[win];
`endif
            end else begin
                state     <= IDLE;
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: table-driven, directed and randomized checks of edge_event_arbiter
module tb_edge_event_arbiter;

    localparam int NCH  = 4;
    localparam int IDW  = 2;
    localparam int DURW = 4;
    localparam int DMAX = 15;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            evt_ready = 1'b0;
    logic            ovf_clear = 1'b0;
    logic [NCH-1:0]  conditioned = '0;
    logic [NCH-1:0]  positiveedge = '0;
    logic [NCH-1:0]  negativeedge = '0;
    logic            evt_valid, evt_rise, overflow;
    logic [IDW-1:0]  evt_chan;
    logic [DURW-1:0] evt_dur;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NCH(NCH), .IDW(IDW), .DURW(DURW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .conditioned(conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_chan(evt_chan),
        .evt_rise(evt_rise),
        .evt_dur(evt_dur),
        .overflow(overflow),
        .ovf_clear(ovf_clear)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending events kept as per-channel slots stamped with their
    // arrival cycle; durations are the cycle distance from the rising pulse.
    int m_valid, m_chan, m_rise, m_dur, m_ovf, m_ptr, cyc;
    int has_r [NCH];
    int has_f [NCH];
    int t_r   [NCH];
    int t_f   [NCH];
    int d_f   [NCH];
    int t_pos [NCH];

    task automatic model_reset();
        m_valid = 0; m_chan = 0; m_rise = 0; m_dur = 0; m_ovf = 0; m_ptr = 0;
        for (int i = 0; i < NCH; i++) begin
            has_r[i] = 0; has_f[i] = 0; t_r[i] = 0; t_f[i] = 0; d_f[i] = 0; t_pos[i] = 0;
        end
    endtask

    task automatic model_step();
        int c = -1;
        int dropped = 0;
        int rs;
        if (m_valid == 0 || evt_ready) begin
            for (int k = 0; k < NCH; k++) begin
                int j = (m_ptr + k) % NCH;
                if (c < 0 && (has_r[j] != 0 || has_f[j] != 0)) c = j;
            end
            if (c >= 0) begin
                rs = (has_r[c] != 0 && (has_f[c] == 0 || t_r[c] <= t_f[c])) ? 1 : 0;
                m_valid = 1;
                m_chan = c;
                m_rise = rs;
                m_dur = rs != 0 ? 0 : d_f[c];
                if (rs != 0) has_r[c] = 0; else has_f[c] = 0;
                m_ptr = (c + 1) % NCH;
            end else begin
                m_valid = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (positiveedge[i]) begin
                t_pos[i] = cyc;
                if (has_r[i] != 0) dropped = 1;
                else begin has_r[i] = 1; t_r[i] = cyc; end
            end
            if (negativeedge[i]) begin
                if (has_f[i] != 0) dropped = 1;
                else begin
                    has_f[i] = 1;
                    t_f[i] = cyc;
                    d_f[i] = (cyc - t_pos[i] > DMAX) ? DMAX : cyc - t_pos[i];
                end
            end
        end
        if (dropped != 0) m_ovf = 1;
        else if (ovf_clear) m_ovf = 0;
        cyc++;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        check("model_valid", 32'(evt_valid), m_valid);
        if (m_valid != 0) begin
            check("model_chan", 32'(evt_chan), m_chan);
            check("model_rise", 32'(evt_rise), m_rise);
            check("model_dur", 32'(evt_dur), m_dur);
        end
        check("model_overflow", 32'(overflow), m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [NCH-1:0] pos;
        logic           rdy;
        logic           v;
        logic [IDW-1:0] ch;
        logic           r;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b1};
        tbl[2]  = '{4'b0000, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[3]  = '{4'b0000, 1'b1, 1'b1, 2'd2, 1'b1};
        tbl[4]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b1};
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{4'b0010, 1'b1, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{4'b1001, 1'b1, 1'b1, 2'd1, 1'b1};
        tbl[8]  = '{4'b0000, 1'b1, 1'b1, 2'd3, 1'b1};
        tbl[9]  = '{4'b0000, 1'b1, 1'b1, 2'd0, 1'b1};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0, 1'b0};

        // Reset, then idle
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check("rst_chan", 32'(evt_chan), 0);
        check("rst_rise", 32'(evt_rise), 0);
        check("rst_dur", 32'(evt_dur), 0);
        repeat (20) begin
            tick();
            check("idle_valid", 32'(evt_valid), 0);
            check("idle_overflow", 32'(overflow), 0);
        end

        // Simultaneous pulses and round-robin fairness
        for (int i = 0; i < 11; i++) begin
            positiveedge = tbl[i].pos;
            evt_ready = tbl[i].rdy;
            tick();
            check("tbl_valid", 32'(evt_valid), 32'(tbl[i].v));
            if (tbl[i].v) begin
                check("tbl_chan", 32'(evt_chan), 32'(tbl[i].ch));
                check("tbl_rise", 32'(evt_rise), 32'(tbl[i].r));
            end
        end
        positiveedge = '0;

        // Single 10-cycle press on ch2
        conditioned[2] = 1'b1;
        positiveedge = 4'b0100;
        tick();
        check("press_pend_valid", 32'(evt_valid), 0);
        positiveedge = '0;
        tick();
        check("press_rise_valid", 32'(evt_valid), 1);
        check("press_rise_chan", 32'(evt_chan), 2);
        check("press_rise_rise", 32'(evt_rise), 1);
        check("press_rise_dur", 32'(evt_dur), 0);
        repeat (8) tick();
        conditioned[2] = 1'b0;
        negativeedge = 4'b0100;
        tick();
        check("press_fall_pend_valid", 32'(evt_valid), 0);
        negativeedge = '0;
        tick();
        check("press_fall_valid", 32'(evt_valid), 1);
        check("press_fall_chan", 32'(evt_chan), 2);
        check("press_fall_rise", 32'(evt_rise), 0);
        check("press_fall_dur", 32'(evt_dur), 10);
        tick();

        // Backpressure, drop and overflow clear
        evt_ready = 1'b0;
        positiveedge = 4'b0001;
        tick();
        positiveedge = '0;
        tick();
        check("bp_chan", 32'(evt_chan), 0);
        positiveedge = 4'b0010;
        tick();
        positiveedge = '0;
        repeat (4) tick();
        check("bp_no_ovf_yet", 32'(overflow), 0);
        positiveedge = 4'b0010;
        tick();
        check("drop_ovf", 32'(overflow), 1);
        positiveedge = '0;
        tick();
        check("drop_hold_valid", 32'(evt_valid), 1);
        check("drop_hold_chan", 32'(evt_chan), 0);
        positiveedge = 4'b0010;
        ovf_clear = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 1);
        positiveedge = '0;
        tick();
        check("ovf_cleared", 32'(overflow), 0);
        ovf_clear = 1'b0;
        evt_ready = 1'b1;
        tick();
        check("drop_ch1_valid", 32'(evt_valid), 1);
        check("drop_ch1_chan", 32'(evt_chan), 1);
        check("drop_ch1_rise", 32'(evt_rise), 1);
        tick();
        check("drop_one_ch1", 32'(evt_valid), 0);

        // Duration saturation on a 40-cycle press
        conditioned[0] = 1'b1;
        positiveedge = 4'b0001;
        tick();
        positiveedge = '0;
        repeat (39) tick();
        conditioned[0] = 1'b0;
        negativeedge = 4'b0001;
        tick();
        negativeedge = '0;
        tick();
        check("sat_valid", 32'(evt_valid), 1);
        check("sat_chan", 32'(evt_chan), 0);
        check("sat_rise", 32'(evt_rise), 0);
        check("sat_dur", 32'(evt_dur), DMAX);
        tick();

        // Reset while an event is presented
        evt_ready = 1'b0;
        positiveedge = 4'b1111;
        tick();
        positiveedge = '0;
        tick();
        check("pre_rst_valid", 32'(evt_valid), 1);
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(evt_valid), 0);
        check("async_rst_overflow", 32'(overflow), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        evt_ready = 1'b1;
        repeat (5) begin
            tick();
            check("no_stale_valid", 32'(evt_valid), 0);
        end

        // Randomized level traffic with varying backpressure
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] lvl;
            lvl = conditioned;
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(7) == 0) lvl[i] = ~lvl[i];
            positiveedge = lvl & ~conditioned;
            negativeedge = ~lvl & conditioned;
            conditioned = lvl;
            evt_ready = (n < 1500) ? ($urandom_range(9) < 7) : ($urandom_range(9) < 3);
            ovf_clear = ($urandom_range(49) == 0);
            tick();
        end
        positiveedge = '0;
        negativeedge = '0;
        ovf_clear = 1'b0;
        evt_ready = 1'b1;
        repeat (10) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
- Collects the edge pulses produced by NCH input conditioners and holds them as pending events, one pair of slots per channel.
- Shares a single event output channel between the NCH channels using round-robin arbitration and a valid/ready handshake.
- Tags each falling event with the channel's press duration in clock cycles.
- Sits between the bank of input conditioners and the downstream command/state logic, so that logic sees a serialized event stream instead of raw per-channel pulses.

Parameters:
- NCH, 4: number of conditioned input channels (2..16).
- IDW, 2: channel-index width; must equal ceil(log2(NCH)).
- DURW, 8: press-duration counter width; the counter saturates.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous reset, active-low.
- conditioned  input  NCH  per-channel conditioned level.
- positiveedge  input  NCH  per-channel 1-cycle rising pulse.
- negativeedge  input  NCH  per-channel 1-cycle falling pulse.
- evt_valid  output  1  event available on the evt_* outputs.
- evt_ready  input  1  consumer accepts the event when high together with evt_valid.
- evt_chan  output  IDW  channel index of the event.
- evt_rise  output  1  1 = rising event, 0 = falling event.
- evt_dur  output  DURW  high-time of the channel for falling events; 0 for rising events.
- overflow  output  1  sticky flag: at least one event has been dropped.
- ovf_clear  input  1  synchronous clear of overflow.

Behaviour:
- Reset: while reset_n is low, asynchronously clear everything:
  - evt_valid=0, evt_chan=0, evt_rise=0, evt_dur=0, overflow=0.
  - All pending flags, duration counters and the round-robin pointer = 0.
  - A reset mid-transfer discards the presented event and all pending events.
- Duration counter, per channel:
  - Clears to 0 on a cycle where positiveedge[i]=1.
  - Otherwise increments while conditioned[i]=1.
  - Saturates at 2^DURW-1; never wraps.
- Pending slots, per channel: pend_rise, pend_fall, dur_cap[DURW], and an order bit marking which pending slot is older.
  - positiveedge[i] sets pend_rise.
  - negativeedge[i] sets pend_fall and captures dur_cap = counter value + 1, saturating.
  - If the target slot is already set and is not being granted this cycle: drop the new event, keep the old one, set overflow.
  - If the target slot is being granted in the same cycle: the slot stays set and holds the new event; overflow is not set.
  - Order bit = the type that arrived while the other slot was empty. Both slots set implies the older one is issued first.
- Arbitration and output register (states IDLE / PRESENT):
  - IDLE (evt_valid=0): if any channel is pending, load the winner into the evt_* outputs, clear that slot, and go to PRESENT.
  - PRESENT: evt_* is held stable while evt_ready=0.
  - On evt_valid & evt_ready: load the next winner in the same cycle if one exists (back-to-back, 1 event per cycle); otherwise go to IDLE.
  - Winner = first channel with a pending slot, scanning from ptr upward modulo NCH. After a grant to channel c, ptr = (c+1) mod NCH.
  - Within the winning channel, the older slot is issued.
- Latency:
  - A pulse sampled at edge k sets pending at edge k.
  - evt_valid rises after edge k+1 if the output was idle; 2-cycle pulse-to-valid.
- overflow:
  - Set on any drop. Stays set until ovf_clear=1.
  - A set in the same cycle as ovf_clear wins; overflow stays 1.
- Pulses on the same cycle across different channels are all captured; none is lost.

Optional Feature:
- Macro EDGE_EVT_TIMESTAMP_EN.
- Defined:
  - Adds a 16-bit free-running counter, cleared by reset and wrapping.
  - Each pending slot stores the counter value at pulse capture.
  - Adds output port evt_ts (16 bits), presented alongside evt_chan with the same stability rules.
- Undefined: no timestamp counter, no storage and no evt_ts port; all other behaviour is identical.

Test Plan:
- Reset then idle, NCH=4: reset_n low for 3 cycles, no pulses -> evt_valid=0, overflow=0 for 20 cycles.
- Single press, evt_ready=1: ch2 conditioned high for 10 cycles, with the matching positiveedge/negativeedge pulses.
  - Rising event: evt_valid 2 cycles after the rising pulse, evt_chan=2, evt_rise=1, evt_dur=0.
  - Falling event: evt_chan=2, evt_rise=0, evt_dur=10.
- Simultaneous pulses, evt_ready=1: positiveedge=4'b1111 in one cycle with ptr=0 -> four consecutive valid cycles, channels 0,1,2,3, all evt_rise=1.
- Fairness: after granting ch1, pulse ch0 and ch3 in the same cycle -> ch3 is issued before ch0.
- Backpressure and drop, evt_ready=0:
  - Pulse ch1 rising, then a second ch1 rising 5 cycles later while the first is still pending -> overflow=1, and exactly one ch1 rise is issued after evt_ready=1.
  - ovf_clear then clears overflow to 0.
- Saturation and reset:
  - DURW=4, ch0 held high for 40 cycles -> falling event with evt_dur=15.
  - Assert reset_n=0 while evt_valid=1 -> evt_valid drops immediately, and no stale event appears after reset is released.
